// File: rtl/hazard_unit_mc_if.sv
// Bundle of hazard-unit inputs from the pipeline and the enables/flushes/selects it drives back.
// The datapath side uses the master modport and the hazard unit uses the slave modport.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic              MdOpE, MemReqM, DMemReadyM;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushM, FlushW;
    logic              MdStartE, MdDoneE;
    logic [CNT_W-1:0]  StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdOpE, MemReqM, DMemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM, FlushW, MdStartE, MdDoneE, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdOpE, MemReqM, DMemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM, FlushW, MdStartE, MdDoneE, StallCycles
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RISC-V pipeline: forwarding, load-use, memory wait-state freeze,
// multi-cycle mul/div sequencing and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_unit_mc_if.slave hz
);
    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0]     CNT_LOAD = CW'(MD_LAT - 2);
    localparam logic [REG_AW-1:0] REG_X0   = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             mem_stall, lw_stall, md_stall, md_start;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && rs != REG_X0 && rs == rd_m)      return 2'b10;
        else if (we_w && rs != REG_X0 && rs == rd_w) return 2'b01;
        else                                         return 2'b00;
    endfunction

    always_comb begin
        mem_stall = hz.MemReqM & ~hz.DMemReadyM;
        lw_stall  = hz.ResultSrcE0 & (hz.RdE != REG_X0) &
                    ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
        md_stall  = ((state_q == IDLE) & hz.MdOpE) | (state_q == BUSY);
        md_start  = (state_q == IDLE) & hz.MdOpE & ~mem_stall & ~hz.PCSrcE;
    end

    // A memory wait freezes everything up to M and bubbles W; it outranks all other hazards.
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushM    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.MdStartE  = 1'b0;
        hz.MdDoneE   = 1'b0;
        if (!rst_n) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else begin
            hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
            hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
            hz.MdStartE  = md_start;
            hz.MdDoneE   = (state_q == DONE);
            if (mem_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else if (hz.PCSrcE) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (md_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.FlushM = 1'b1;
            end else if (lw_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
        end
    end

    // BUSY counts down regardless of memory waits; DONE is held until the freeze lifts.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE: begin
                if (!mem_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (hz.StallF && stall_cycles_q != CNT_MAX)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.StallCycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios plus randomized traffic
// compared against an elapsed-time model of the mul/div op.
module tb_hazard_unit_mc;
    localparam int REG_AW  = 5;
    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_s_n;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();
    hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(4))     hs ();

    hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz.slave)
    );
    hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_s_n), .hz(hs.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: op in flight and cycles elapsed since its start edge.
    bit m_active = 1'b0;
    int m_age    = 0;
    int m_cnt    = 0;
    logic [13:0] exp_vec;
    logic [13:0] obs;

    assign obs = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                  hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW, hz.MdStartE, hz.MdDoneE};

    function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] rs);
        if (rs != 0 && hz.RegWriteM && rs == hz.RdM) return 2'b10;
        if (rs != 0 && hz.RegWriteW && rs == hz.RdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_vec();
        logic mem, lw, md_hold, start;
        logic [3:0] st, fl;
        if (!rst_n) return 14'b00_00_0000_1100_00;
        mem     = hz.MemReqM && !hz.DMemReadyM;
        lw      = hz.ResultSrcE0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        md_hold = m_active ? (m_age < MD_LAT) : hz.MdOpE;
        start   = !m_active && hz.MdOpE && !mem && !hz.PCSrcE;
        st = 4'b0000;
        fl = 4'b0000;
        if (mem)            begin st = 4'b1111; fl = 4'b0001; end
        else if (hz.PCSrcE) begin fl = 4'b1100; end
        else if (md_hold)   begin st = 4'b1110; fl = 4'b0010; end
        else if (lw)        begin st = 4'b1100; fl = 4'b0100; end
        return {m_fwd(hz.Rs1E), m_fwd(hz.Rs2E), st, fl, start,
                m_active && m_age >= MD_LAT};
    endfunction

    task automatic advance();
        logic [13:0] v;
        logic mem;
        v   = model_vec();
        mem = hz.MemReqM && !hz.DMemReadyM;
        if (!rst_n) begin
            m_active = 1'b0;
            m_age    = 0;
            m_cnt    = 0;
        end else begin
            if (v[9] && m_cnt < CNT_MAX) m_cnt++;
            if (m_active) begin
                if (m_age >= MD_LAT) begin
                    if (!mem) m_active = 1'b0;
                end else m_age++;
            end else if (v[1]) begin
                m_active = 1'b1;
                m_age    = 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE0 = 0; hz.PCSrcE = 0;
        hz.MdOpE = 0; hz.MemReqM = 0; hz.DMemReadyM = 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            hz.MdOpE = 1; hz.MemReqM = 1; hz.DMemReadyM = 0; hz.PCSrcE = 1;
            hz.RegWriteM = 1; hz.RdM = 5'd3; hz.Rs1E = 5'd3;
            #1;
            total++;
            if (obs !== 14'b00_00_0000_1100_00) begin
                bad++;
                $display("[TB] FAIL reset_outputs: got %b want %b", obs, 14'b00_00_0000_1100_00);
            end
            advance();
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        #1;
        total++;
        if (hz.StallCycles !== '0 || hz.MdDoneE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: cnt=%0d done=%b want 0/0", hz.StallCycles, hz.MdDoneE);
        end
        advance();
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        hz.RdM = 5'd5; hz.RdW = 5'd5; hz.RegWriteM = 1; hz.RegWriteW = 1; hz.Rs1E = 5'd5;
        #1;
        total++;
        if (hz.ForwardAE !== 2'b10) begin bad++; $display("[TB] FAIL fwd_a_mem: got %b want 10", hz.ForwardAE); end
        hz.RegWriteM = 0;
        #1;
        total++;
        if (hz.ForwardAE !== 2'b01) begin bad++; $display("[TB] FAIL fwd_a_wb: got %b want 01", hz.ForwardAE); end
        hz.Rs1E = 5'd0;
        #1;
        total++;
        if (hz.ForwardAE !== 2'b00) begin bad++; $display("[TB] FAIL fwd_a_x0: got %b want 00", hz.ForwardAE); end
        hz.RegWriteM = 1; hz.RdW = 5'd9; hz.Rs2E = 5'd9;
        #1;
        total++;
        if (hz.ForwardBE !== 2'b01) begin bad++; $display("[TB] FAIL fwd_b_wb: got %b want 01", hz.ForwardBE); end
        advance();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        hz.ResultSrcE0 = 1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        total++;
        if ({hz.StallF, hz.StallD, hz.StallE, hz.FlushE} !== 4'b1101) begin
            bad++;
            $display("[TB] FAIL load_use: got %b want 1101", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE});
        end
        advance();
        @(negedge clk);
        hz.RdE = 5'd0; hz.Rs2D = 5'd0;
        #1;
        total++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL load_use_x0: got %b want 000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        advance();
    endtask

    task automatic test_muldiv();
        int base;
        base = m_cnt;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            clear_inputs();
            hz.MdOpE = (c <= 4);
            #1;
            if (c == 0) begin
                total++;
                if (hz.MdStartE !== 1'b1) begin bad++; $display("[TB] FAIL md_start: got %b want 1", hz.MdStartE); end
            end
            if (c < MD_LAT) begin
                total++;
                if ({hz.StallF, hz.StallD, hz.StallE, hz.FlushM, hz.MdDoneE} !== 5'b11110) begin
                    bad++;
                    $display("[TB] FAIL md_hold c=%0d: got %b want 11110", c,
                             {hz.StallF, hz.StallD, hz.StallE, hz.FlushM, hz.MdDoneE});
                end
            end else if (c == MD_LAT) begin
                total++;
                if ({hz.StallF, hz.StallD, hz.StallE, hz.FlushM, hz.MdDoneE} !== 5'b00001) begin
                    bad++;
                    $display("[TB] FAIL md_done: got %b want 00001",
                             {hz.StallF, hz.StallD, hz.StallE, hz.FlushM, hz.MdDoneE});
                end
            end else begin
                total++;
                if (hz.StallCycles !== CNT_W'(base + MD_LAT)) begin
                    bad++;
                    $display("[TB] FAIL md_stall_count: got %0d want %0d", hz.StallCycles, base + MD_LAT);
                end
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            clear_inputs();
            hz.MdOpE      = (c <= 7);
            hz.MemReqM    = (c >= 1 && c <= 6);
            hz.DMemReadyM = !(c >= 1 && c <= 6);
            #1;
            if (c >= 1 && c <= 6) begin
                total++;
                if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushM, hz.MdDoneE}
                    !== {6'b111110, c >= MD_LAT}) begin
                    bad++;
                    $display("[TB] FAIL mem_wait c=%0d: got %b want %b", c,
                             {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushM, hz.MdDoneE},
                             {6'b111110, c >= MD_LAT});
                end
            end else if (c == 7) begin
                total++;
                if ({hz.StallF, hz.MdDoneE} !== 2'b01) begin
                    bad++;
                    $display("[TB] FAIL mem_wait_release: got %b want 01", {hz.StallF, hz.MdDoneE});
                end
            end else if (c == 8) begin
                total++;
                if (hz.MdDoneE !== 1'b0) begin bad++; $display("[TB] FAIL mem_wait_idle: got %b want 0", hz.MdDoneE); end
            end
            advance();
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        hz.PCSrcE = 1; hz.ResultSrcE0 = 1; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.MdOpE = 1;
        #1;
        total++;
        if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallD, hz.MdStartE} !== 5'b11000) begin
            bad++;
            $display("[TB] FAIL branch_over_lw: got %b want 11000",
                     {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD, hz.MdStartE});
        end
        advance();
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clear_inputs();
            hz.MdOpE = 1;
            advance();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 14'b00_00_0000_1100_00) begin
            bad++;
            $display("[TB] FAIL reset_midop_outputs: got %b want %b", obs, 14'b00_00_0000_1100_00);
        end
        advance();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            clear_inputs();
            #1;
            total++;
            if (hz.MdDoneE !== 1'b0 || (c == 0 && hz.StallCycles !== '0) || hz.StallF !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_midop c=%0d: done=%b cnt=%0d stall=%b want 0/0/0",
                         c, hz.MdDoneE, hz.StallCycles, hz.StallF);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            rst_n          = ($urandom_range(0, 59) != 0);
            hz.Rs1D        = REG_AW'($urandom_range(0, 3));
            hz.Rs2D        = REG_AW'($urandom_range(0, 3));
            hz.Rs1E        = REG_AW'($urandom_range(0, 3));
            hz.Rs2E        = REG_AW'($urandom_range(0, 3));
            hz.RdE         = REG_AW'($urandom_range(0, 3));
            hz.RdM         = REG_AW'($urandom_range(0, 3));
            hz.RdW         = REG_AW'($urandom_range(0, 3));
            hz.RegWriteM   = 1'($urandom);
            hz.RegWriteW   = 1'($urandom);
            hz.ResultSrcE0 = 1'($urandom);
            hz.PCSrcE      = ($urandom_range(0, 5) == 0);
            hz.MdOpE       = ($urandom_range(0, 2) == 0);
            hz.MemReqM     = 1'($urandom);
            hz.DMemReadyM  = ($urandom_range(0, 2) != 0);
            #1;
            exp_vec = model_vec();
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("[TB] FAIL random_outputs n=%0d: got %b want %b", n, obs, exp_vec);
            end
            total++;
            if (hz.StallCycles !== CNT_W'(m_cnt)) begin
                bad++;
                $display("[TB] FAIL random_stall_count n=%0d: got %0d want %0d", n, hz.StallCycles, m_cnt);
            end
            advance();
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_saturation();
        int want;
        @(negedge clk);
        rst_s_n = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        hs.MemReqM = 1; hs.DMemReadyM = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            want = (k > 15) ? 15 : k;
            if (k == 10 || k == 15 || k == 20) begin
                total++;
                if (hs.StallCycles !== 4'(want)) begin
                    bad++;
                    $display("[TB] FAIL saturation k=%0d: got %0d want %0d", k, hs.StallCycles, want);
                end
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        clear_inputs();
        hs.Rs1D = '0; hs.Rs2D = '0; hs.Rs1E = '0; hs.Rs2E = '0;
        hs.RdE = '0; hs.RdM = '0; hs.RdW = '0;
        hs.RegWriteM = 0; hs.RegWriteW = 0; hs.ResultSrcE0 = 0; hs.PCSrcE = 0;
        hs.MdOpE = 0; hs.MemReqM = 0; hs.DMemReadyM = 1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_mem_wait();
        test_branch();
        test_reset_midop();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
